// File: rtl/proc_datapath_if.sv
// proc_datapath_if: control/data bundle between the processor control FSM
// (master) and the register-file/ALU datapath (slave).
//   run         global enable; no datapath register changes while low
//   DIN         memory read data
//   R0in..R7in  load Rn from bus        R0out..R7out  drive Rn onto bus
//   Gout/DINout drive G / DIN onto bus  Ain/Gin       load A / G
//   AddSub      0 = A+bus, 1 = A-bus    Address_in/Dout_in  load ADDR / DOUT
//   W_D         memory write request    incr_pc       increment R7
//   BusWires, G, ADDR, DOUT, W, PC, bus_err  datapath outputs
interface proc_datapath_if #(
    parameter int WIDTH = 9
);
    logic             run;
    logic [WIDTH-1:0] DIN;
    logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic             Gout, DINout, Ain, Gin, AddSub;
    logic             Address_in, Dout_in, W_D, incr_pc;
    logic [WIDTH-1:0] BusWires, G, ADDR, DOUT, PC;
    logic             W, bus_err;

    modport master (
        output run, DIN,
        output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        output Gout, DINout, Ain, Gin, AddSub, Address_in, Dout_in, W_D, incr_pc,
        input  BusWires, G, ADDR, DOUT, W, PC, bus_err
    );

    modport slave (
        input  run, DIN,
        input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        input  Gout, DINout, Ain, Gin, AddSub, Address_in, Dout_in, W_D, incr_pc,
        output BusWires, G, ADDR, DOUT, W, PC, bus_err
    );
endinterface

// File: rtl/proc_datapath.sv
// proc_datapath: register file R0-R7 (R7 = PC), A/G ALU registers, shared
// priority bus and memory-interface registers (ADDR, DOUT, W). Driven one
// enable per control line by the processor control FSM.
// Ports:
//   clk     clock
//   rst     asynchronous, active-low reset
//   bus_if  proc_datapath_if.slave (controls in, BusWires/G/ADDR/DOUT/W/PC/bus_err out)
// Parameters: WIDTH (datapath width), PC_RESET (R7 value after reset).
// Optional: define PROC_DATAPATH_BUS_CHECK_EN to build the sticky bus_err
// flag that records any cycle with two or more bus drivers.

// One general-purpose register with load enable and reset value.
module proc_datapath_reg #(
    parameter int               WIDTH   = 9,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] val_d, val_q;

    always_comb begin
        val_d = val_q;
        if (en) val_d = d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) val_q <= RST_VAL;
        else      val_q <= val_d;
    end

    assign q = val_q;
endmodule

module proc_datapath #(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    proc_datapath_if.slave    bus_if
);
    localparam int NREG = 8;

    logic [NREG-1:0]            r_in, r_out, r_en;
    logic [NREG-1:0][WIDTH-1:0] r_d, r_q;
    logic [WIDTH-1:0]           bus, alu;
    logic [WIDTH-1:0]           a_d, a_q, g_d, g_q, addr_d, addr_q, dout_d, dout_q;
    logic                       w_d, w_q;

    assign r_in  = {bus_if.R7in, bus_if.R6in, bus_if.R5in, bus_if.R4in,
                    bus_if.R3in, bus_if.R2in, bus_if.R1in, bus_if.R0in};
    assign r_out = {bus_if.R7out, bus_if.R6out, bus_if.R5out, bus_if.R4out,
                    bus_if.R3out, bus_if.R2out, bus_if.R1out, bus_if.R0out};

    // Priority mux: DIN, then G, then lowest-numbered register. The loop runs
    // high-to-low so the lowest asserted index is the last (winning) assignment.
    always_comb begin
        bus = '0;
        if (bus_if.DINout)    bus = bus_if.DIN;
        else if (bus_if.Gout) bus = g_q;
        else begin
            for (int i = NREG - 1; i >= 0; i--)
                if (r_out[i]) bus = r_q[i];
        end
    end

    assign alu = bus_if.AddSub ? (a_q - bus) : (a_q + bus);

    // R7 doubles as PC: a bus load beats the increment in the same cycle.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == NREG - 1) begin : g_pc
            assign r_d[i]  = r_in[i] ? bus : r_q[i] + 1'b1;
            assign r_en[i] = bus_if.run & (r_in[i] | bus_if.incr_pc);
        end else begin : g_gp
            assign r_d[i]  = bus;
            assign r_en[i] = bus_if.run & r_in[i];
        end
        proc_datapath_reg #(
            .WIDTH  (WIDTH),
            .RST_VAL((i == NREG - 1) ? PC_RESET : '0)
        ) u_reg (
            .clk(clk),
            .rst(rst),
            .en (r_en[i]),
            .d  (r_d[i]),
            .q  (r_q[i])
        );
    end

    always_comb begin
        a_d    = a_q;
        g_d    = g_q;
        addr_d = addr_q;
        dout_d = dout_q;
        w_d    = w_q;
        if (bus_if.run) begin
            if (bus_if.Ain)        a_d    = bus;
            if (bus_if.Gin)        g_d    = alu;
            if (bus_if.Address_in) addr_d = bus;
            if (bus_if.Dout_in)    dout_d = bus;
            w_d = bus_if.W_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            g_q    <= '0;
            addr_q <= '0;
            dout_q <= '0;
            w_q    <= 1'b0;
        end else begin
            a_q    <= a_d;
            g_q    <= g_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            w_q    <= w_d;
        end
    end

`ifdef PROC_DATAPATH_BUS_CHECK_EN
    logic bus_err_d, bus_err_q;
    logic [3:0] n_drv;

    assign n_drv = 4'($countones({bus_if.DINout, bus_if.Gout, r_out}));

    always_comb begin
        bus_err_d = bus_err_q;
        if (bus_if.run && n_drv >= 4'd2) bus_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus_err_q <= 1'b0;
        else      bus_err_q <= bus_err_d;
    end

    assign bus_if.bus_err = bus_err_q;
`else
    assign bus_if.bus_err = 1'b0;
`endif

    assign bus_if.BusWires = bus;
    assign bus_if.G        = g_q;
    assign bus_if.ADDR     = addr_q;
    assign bus_if.DOUT     = dout_q;
    assign bus_if.W        = w_q;
    assign bus_if.PC       = r_q[NREG-1];
endmodule

// File: tb/tb_proc_datapath.sv
// tb_proc_datapath: directed test-plan sequence plus randomized control
// traffic, all outputs compared against a behavioural model.
module tb_proc_datapath;
    localparam int WIDTH = 9;
`ifdef PROC_DATAPATH_BUS_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_datapath_if #(.WIDTH(WIDTH)) bif();
    proc_datapath #(.WIDTH(WIDTH), .PC_RESET(9'h000)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bif)
    );

    // stimulus
    logic             run;
    logic [WIDTH-1:0] din;
    logic [7:0]       rin, rout;
    logic             gout, dinout, ain, gin, addsub, addr_in, dout_in, w_d, incr;

    // model state
    logic [WIDTH-1:0] m_r [8];
    logic [WIDTH-1:0] m_a, m_g, m_addr, m_dout;
    logic             m_w, m_err;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr();
        run = 1'b1; din = '0; rin = '0; rout = '0;
        gout = 0; dinout = 0; ain = 0; gin = 0; addsub = 0;
        addr_in = 0; dout_in = 0; w_d = 0; incr = 0;
    endtask

    task automatic apply();
        bif.run = run; bif.DIN = din;
        {bif.R7in, bif.R6in, bif.R5in, bif.R4in, bif.R3in, bif.R2in, bif.R1in, bif.R0in} = rin;
        {bif.R7out, bif.R6out, bif.R5out, bif.R4out, bif.R3out, bif.R2out, bif.R1out, bif.R0out} = rout;
        bif.Gout = gout; bif.DINout = dinout; bif.Ain = ain; bif.Gin = gin;
        bif.AddSub = addsub; bif.Address_in = addr_in; bif.Dout_in = dout_in;
        bif.W_D = w_d; bif.incr_pc = incr;
    endtask

    function automatic logic [WIDTH-1:0] m_bus();
        if (dinout) return din;
        if (gout) return m_g;
        for (int i = 0; i < 8; i++) if (rout[i]) return m_r[i];
        return '0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 7; i++) m_r[i] = '0;
        m_r[7] = 9'h000;
        m_a = '0; m_g = '0; m_addr = '0; m_dout = '0; m_w = 0; m_err = 0;
    endtask

    task automatic m_update();
        logic [WIDTH-1:0] b;
        int n;
        if (!run) return;
        b = m_bus();
        n = int'(dinout) + int'(gout);
        for (int i = 0; i < 8; i++) n += int'(rout[i]);
        if (gin) m_g = addsub ? m_a - b : m_a + b;
        for (int i = 0; i < 8; i++) if (rin[i]) m_r[i] = b;
        if (!rin[7] && incr) m_r[7] = m_r[7] + 1'b1;
        if (ain) m_a = b;
        if (addr_in) m_addr = b;
        if (dout_in) m_dout = b;
        m_w = w_d;
        if (CHK_EN && n >= 2) m_err = 1'b1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".G"},    bif.G,       m_g);
        chk({tag, ".ADDR"}, bif.ADDR,    m_addr);
        chk({tag, ".DOUT"}, bif.DOUT,    m_dout);
        chk({tag, ".W"},    bif.W,       m_w);
        chk({tag, ".PC"},   bif.PC,      m_r[7]);
        chk({tag, ".err"},  bif.bus_err, m_err);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        apply();
        #1 chk({tag, ".bus"}, bif.BusWires, m_bus());
        @(posedge clk);
        m_update();
        #1 chk_all(tag);
    endtask

    task automatic peek(input int i, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        clr();
        rout[i] = 1'b1;
        apply();
        #1 chk($sformatf("peek_r%0d", i), bif.BusWires, exp);
    endtask

    initial begin
        clr();
        apply();
        rst = 1'b0;
        m_reset();
        #12 chk_all("reset");
        for (int i = 0; i < 7; i++) peek(i, '0);
        @(negedge clk) rst = 1'b1;

        // PC increment and address from PC
        clr(); incr = 1;
        repeat (3) step("incr");
        chk("pc3", bif.PC, 3);
        clr(); rout[7] = 1; addr_in = 1; step("pc2addr");
        chk("addr3", bif.ADDR, 3);

        // 5 + 3
        clr(); din = 9'h005; dinout = 1; rin[1] = 1; step("ld_r1");
        clr(); din = 9'h003; dinout = 1; rin[2] = 1; step("ld_r2");
        clr(); rout[1] = 1; ain = 1; step("r1_a");
        clr(); rout[2] = 1; gin = 1; step("add");
        chk("add_g", bif.G, 9'h008);
        clr(); gout = 1; rin[3] = 1; step("g_r3");
        peek(3, 9'h008);

        // 2 - 3 wraps
        clr(); din = 9'h002; dinout = 1; ain = 1; step("ld_a");
        clr(); rout[2] = 1; gin = 1; addsub = 1; step("sub");
        chk("sub_g", bif.G, 9'h1FF);
        clr(); gout = 1; rin[0] = 1; step("g_r0");
        peek(0, 9'h1FF);

        // Gin & Gout together: G <= A + old G = 2 + 1FF = 001
        clr(); gout = 1; gin = 1; step("g_loop");
        chk("g_loop_g", bif.G, 9'h001);

        // same register read and reload
        clr(); rout[3] = 1; rin[3] = 1; step("r3_self");
        peek(3, 9'h008);

        // PC wrap and load-beats-increment
        clr(); din = 9'h1FF; dinout = 1; rin[7] = 1; step("ld_pc");
        clr(); incr = 1; step("pc_wrap");
        chk("pc_wrap", bif.PC, 9'h000);
        clr(); din = 9'h040; dinout = 1; rin[7] = 1; incr = 1; step("pc_ld_inc");
        chk("pc_ld_inc", bif.PC, 9'h040);

        // store path
        clr(); din = 9'h0AA; dinout = 1; rin[4] = 1; step("ld_r4");
        clr(); din = 9'h010; dinout = 1; rin[5] = 1; step("ld_r5");
        clr(); rout[4] = 1; dout_in = 1; step("r4_dout");
        clr(); rout[5] = 1; addr_in = 1; step("r5_addr");
        clr(); w_d = 1; step("wr");
        chk("w_hi", bif.W, 1);
        clr(); step("wr_done");
        chk("w_lo", bif.W, 0);
        chk("dout_aa", bif.DOUT, 9'h0AA);
        chk("addr_10", bif.ADDR, 9'h010);

        // run=0 freezes everything
        clr(); run = 0; din = 9'h155; dinout = 1; rin = 8'hFF; ain = 1; gin = 1;
        addr_in = 1; dout_in = 1; w_d = 1; incr = 1;
        repeat (5) step("hold");
        chk("hold_pc", bif.PC, 9'h040);
        peek(4, 9'h0AA);

        // two bus drivers
        clr(); din = 9'h011; dinout = 1; rin[1] = 1; step("ld_r1b");
        clr(); din = 9'h022; dinout = 1; rin[2] = 1; step("ld_r2b");
        @(negedge clk);
        clr(); rout[1] = 1; rout[2] = 1; apply();
        #1 chk("conflict_bus", bif.BusWires, 9'h011);
        step("conflict");
        chk("conflict_err", bif.bus_err, CHK_EN);
        clr(); repeat (2) step("err_hold");
        chk("err_held", bif.bus_err, CHK_EN);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            clr();
            run     = ($urandom_range(9) != 0);
            din     = WIDTH'($urandom);
            rin     = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rout    = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
            dinout  = ($urandom_range(4) == 0);
            gout    = ($urandom_range(4) == 0);
            ain     = $urandom_range(1);
            gin     = $urandom_range(1);
            addsub  = $urandom_range(1);
            addr_in = $urandom_range(1);
            dout_in = $urandom_range(1);
            w_d     = $urandom_range(1);
            incr    = $urandom_range(1);
            step("rand");
        end

        // asynchronous reset away from any edge
        @(negedge clk);
        #2 rst = 1'b0;
        m_reset();
        #1 chk_all("async_rst");
        chk("async_rst_pc", bif.PC, 0);
        peek(5, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
